// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared word-addressed memory port: data side has
// priority with an anti-starvation streak limit, and read responses are routed via an owner FIFO.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30,
    parameter int MAX_STREAK     = 4,
    parameter int OUTSTANDING    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req_valid,
    output logic                      ic_req_ready,
    input  logic [WORD_ADDR_BITS-1:0] ic_req_addr,
    input  logic [CPU_WIDTH-1:0]      ic_req_data,
    input  logic [3:0]                ic_req_write,
    output logic                      ic_resp_valid,
    output logic [CPU_WIDTH-1:0]      ic_resp_data,
    input  logic                      dc_req_valid,
    output logic                      dc_req_ready,
    input  logic [WORD_ADDR_BITS-1:0] dc_req_addr,
    input  logic [CPU_WIDTH-1:0]      dc_req_data,
    input  logic [3:0]                dc_req_write,
    output logic                      dc_resp_valid,
    output logic [CPU_WIDTH-1:0]      dc_resp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_WIDTH-1:0]      mem_req_data,
    output logic [3:0]                mem_req_write,
    input  logic                      mem_resp_valid,
    input  logic [CPU_WIDTH-1:0]      mem_resp_data,
    output logic                      arb_err
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] FULL       = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IC,
        GNT_DC
    } grant_e;

    grant_e                 grant;
    logic                   ic_elig, dc_elig, slot_free;
    logic                   accept, push, pop, fifo_empty, head;

    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [SW-1:0]          streak_q, streak_d;
    logic                   arb_err_q, arb_err_d;

    // A read needs a free owner slot; a pop in the same cycle does not count as free.
    always_comb begin
        slot_free = count_q < FULL;
        ic_elig   = ic_req_valid && ((ic_req_write != 4'b0) || slot_free);
        dc_elig   = dc_req_valid && ((dc_req_write != 4'b0) || slot_free);
        grant     = GNT_NONE;
        if (ic_elig && dc_elig) begin
            grant = (streak_q == STREAK_MAX) ? GNT_IC : GNT_DC;
        end else if (dc_elig) begin
            grant = GNT_DC;
        end else if (ic_elig) begin
            grant = GNT_IC;
        end
    end

    always_comb begin
        mem_req_valid = !reset && (grant != GNT_NONE);
        mem_req_addr  = dc_req_addr;
        mem_req_data  = dc_req_data;
        mem_req_write = dc_req_write;
        if (grant == GNT_IC) begin
            mem_req_addr  = ic_req_addr;
            mem_req_data  = ic_req_data;
            mem_req_write = ic_req_write;
        end
        ic_req_ready  = !reset && (grant == GNT_IC) && mem_req_ready;
        dc_req_ready  = !reset && (grant == GNT_DC) && mem_req_ready;
        accept        = mem_req_valid && mem_req_ready;
        push          = accept && (mem_req_write == 4'b0);
        fifo_empty    = (count_q == '0);
        pop           = mem_resp_valid && !fifo_empty;
        head          = owner_q[rd_ptr_q];
        ic_resp_valid = !reset && pop && !head;
        dc_resp_valid = !reset && pop && head;
        ic_resp_data  = mem_resp_data;
        dc_resp_data  = mem_resp_data;
        arb_err       = arb_err_q;
    end

    always_comb begin
        streak_d = streak_q;
        if (accept && (grant == GNT_DC) && ic_req_valid) begin
            if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
            end
        end else if ((accept && (grant == GNT_IC)) || !ic_req_valid) begin
            streak_d = '0;
        end

        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            owner_d[wr_ptr_q] = (grant == GNT_DC);
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A response with nothing outstanding is dropped and flagged until reset.
        arb_err_d = arb_err_q || (mem_resp_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            owner_q   <= '0;
            streak_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            arb_err_q <= arb_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected accepts and routed responses are
// queued at stimulus time and checked by an independent monitor on the falling edge.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct packed {
        logic          side;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    wr;
    } acc_t;

    typedef struct packed {
        logic          side;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, dc_req_valid;
    logic          ic_req_ready, dc_req_ready;
    logic [AW-1:0] ic_req_addr, dc_req_addr;
    logic [DW-1:0] ic_req_data, dc_req_data;
    logic [3:0]    ic_req_write, dc_req_write;
    logic          ic_resp_valid, dc_resp_valid;
    logic [DW-1:0] ic_resp_data, dc_resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [3:0]    mem_req_write;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          arb_err;

    logic          auto_mode;
    logic          auto_valid = 1'b0;
    logic [DW-1:0] auto_data = '0;
    logic          man_valid;
    logic [DW-1:0] man_data;

    int    checks = 0;
    int    errors = 0;
    acc_t  exp_acc[$];
    resp_t exp_resp[$];
    acc_t  ea;
    resp_t er;

    mem_arbiter #(
        .CPU_WIDTH(DW), .WORD_ADDR_BITS(AW), .MAX_STREAK(4), .OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_data(ic_req_data), .ic_req_write(ic_req_write),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_write(dc_req_write),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        if (a == 30'h10) return 32'hDEADBEEF;
        return 32'hC0DE0000 | {2'b00, a};
    endfunction

    // Single-cycle memory: a read accepted this cycle answers on the next one.
    always @(posedge clk) begin
        auto_valid <= mem_req_valid && mem_req_ready && (mem_req_write == 4'b0);
        auto_data  <= memWord(mem_req_addr);
    end

    assign mem_resp_valid = auto_mode ? auto_valid : man_valid;
    assign mem_resp_data  = auto_mode ? auto_data  : man_data;

    // Monitor: every accepted request and every routed response must match the queues.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            checks++;
            if (exp_acc.size() == 0) begin
                errors++;
                $display("[TB] FAIL acc_unexpected got addr=%h wr=%b, expected no accept", mem_req_addr, mem_req_write);
            end else begin
                ea = exp_acc.pop_front();
                if ((ic_req_ready == dc_req_ready) || (dc_req_ready != ea.side) || (mem_req_addr != ea.addr)
                    || (mem_req_data != ea.data) || (mem_req_write != ea.wr)) begin
                    errors++;
                    $display("[TB] FAIL acc got icr=%0b dcr=%0b addr=%h data=%h wr=%b, expected side=%0d addr=%h data=%h wr=%b",
                             ic_req_ready, dc_req_ready, mem_req_addr, mem_req_data, mem_req_write,
                             ea.side, ea.addr, ea.data, ea.wr);
                end
            end
        end
        if (ic_resp_valid || dc_resp_valid) begin
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("[TB] FAIL resp_unexpected got ic=%0b dc=%0b data=%h, expected none", ic_resp_valid, dc_resp_valid, mem_resp_data);
            end else begin
                er = exp_resp.pop_front();
                if ((ic_resp_valid && dc_resp_valid) || (dc_resp_valid != er.side)
                    || ((er.side ? dc_resp_data : ic_resp_data) != er.data)) begin
                    errors++;
                    $display("[TB] FAIL resp got ic=%0b dc=%0b icd=%h dcd=%h, expected side=%0d data=%h",
                             ic_resp_valid, dc_resp_valid, ic_resp_data, dc_resp_data, er.side, er.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic icv, input logic [AW-1:0] ica, input logic [DW-1:0] icd,
                                 input logic [3:0] icw, input logic dcv, input logic [AW-1:0] dca,
                                 input logic [DW-1:0] dcd, input logic [3:0] dcw);
        ic_req_valid = icv; ic_req_addr = ica; ic_req_data = icd; ic_req_write = icw;
        dc_req_valid = dcv; dc_req_addr = dca; dc_req_data = dcd; dc_req_write = dcw;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        step();
        applyStimulus(0, '0, '0, 4'b0, 0, '0, '0, 4'b0);
        man_valid = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst_ic_req_ready", {31'b0, ic_req_ready}, 32'd0);
        checkOutput("rst_dc_req_ready", {31'b0, dc_req_ready}, 32'd0);
        checkOutput("rst_ic_resp_valid", {31'b0, ic_resp_valid}, 32'd0);
        checkOutput("rst_dc_resp_valid", {31'b0, dc_resp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_req_ready = 1'b1; auto_mode = 1'b1;
        man_valid = 1'b0; man_data = '0;
        applyStimulus(1, 30'h1, '0, 4'b0, 1, 30'h2, '0, 4'b0);
        @(negedge clk);
        checkResetOutputs();
        checkOutput("rst_arb_err", {31'b0, arb_err}, 32'd0);
        step();
        reset = 1'b0;
        applyStimulus(0, '0, '0, 4'b0, 0, '0, '0, 4'b0);

        $display("[TB] test 1: lone ic read");
        step();
        applyStimulus(1, 30'h10, '0, 4'b0, 0, '0, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h10, 32'h0, 4'b0});
        exp_resp.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        checkOutput("t1_ic_req_ready", {31'b0, ic_req_ready}, 32'd1);
        idle();
        @(negedge clk);
        checkOutput("t1_ic_resp_valid", {31'b0, ic_resp_valid}, 32'd1);

        $display("[TB] test 2: streak limit dc x4 then ic");
        for (int i = 0; i < 10; i++) begin
            step();
            applyStimulus(1, 30'h100, '0, 4'b0, 1, 30'h200, '0, 4'b0);
            if ((i % 5) == 4) begin
                exp_acc.push_back('{1'b0, 30'h100, 32'h0, 4'b0});
                exp_resp.push_back('{1'b0, 32'hC0DE0100});
            end else begin
                exp_acc.push_back('{1'b1, 30'h200, 32'h0, 4'b0});
                exp_resp.push_back('{1'b1, 32'hC0DE0200});
            end
        end
        idle();
        idle();
        auto_mode = 1'b0;

        $display("[TB] test 3: dc write while ic read pending");
        step();
        applyStimulus(1, 30'h8, '0, 4'b0, 0, '0, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h8, 32'h0, 4'b0});
        exp_resp.push_back('{1'b0, 32'h5555AAAA});
        step();
        applyStimulus(0, '0, '0, 4'b0, 1, 30'h8, 32'h1234, 4'b0011);
        exp_acc.push_back('{1'b1, 30'h8, 32'h1234, 4'b0011});
        @(negedge clk);
        checkOutput("t3_dc_write_ready", {31'b0, dc_req_ready}, 32'd1);
        idle();
        man_valid = 1'b1; man_data = 32'h5555AAAA;
        @(negedge clk);
        checkOutput("t3_ic_resp_valid", {31'b0, ic_resp_valid}, 32'd1);
        idle();

        $display("[TB] test 4: owner FIFO full");
        mem_req_ready = 1'b0;
        applyStimulus(0, '0, '0, 4'b0, 1, 30'h50, 32'hAB000000, 4'b1000);
        @(negedge clk);
        checkOutput("t4_stall_mem_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("t4_stall_dc_ready", {31'b0, dc_req_ready}, 32'd0);
        step();
        mem_req_ready = 1'b1;
        exp_acc.push_back('{1'b1, 30'h50, 32'hAB000000, 4'b1000});
        step();
        applyStimulus(1, 30'h20, '0, 4'b0, 0, '0, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h20, 32'h0, 4'b0});
        exp_resp.push_back('{1'b0, 32'h11111111});
        step();
        applyStimulus(1, 30'h24, '0, 4'b0, 0, '0, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h24, 32'h0, 4'b0});
        exp_resp.push_back('{1'b0, 32'h22222222});
        step();
        applyStimulus(1, 30'h30, 32'hCAFEF00D, 4'b1111, 1, 30'h40, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h30, 32'hCAFEF00D, 4'b1111});
        @(negedge clk);
        checkOutput("t4_full_dc_ready", {31'b0, dc_req_ready}, 32'd0);
        checkOutput("t4_write_ic_ready", {31'b0, ic_req_ready}, 32'd1);
        step();
        applyStimulus(0, '0, '0, 4'b0, 1, 30'h40, '0, 4'b0);
        man_valid = 1'b1; man_data = 32'h11111111;
        @(negedge clk);
        checkOutput("t4_pop_no_free", {31'b0, dc_req_ready}, 32'd0);
        step();
        man_valid = 1'b0;
        exp_acc.push_back('{1'b1, 30'h40, 32'h0, 4'b0});
        exp_resp.push_back('{1'b1, 32'h33333333});
        @(negedge clk);
        checkOutput("t4_dc_read_ready", {31'b0, dc_req_ready}, 32'd1);
        idle();
        man_valid = 1'b1; man_data = 32'h22222222;
        idle();
        man_valid = 1'b1; man_data = 32'h33333333;
        idle();

        $display("[TB] test 5: response with FIFO empty");
        man_valid = 1'b1; man_data = 32'h99;
        @(negedge clk);
        checkOutput("t5_err_not_yet", {31'b0, arb_err}, 32'd0);
        idle();
        @(negedge clk);
        checkOutput("t5_err_set", {31'b0, arb_err}, 32'd1);
        idle();
        @(negedge clk);
        checkOutput("t5_err_sticky", {31'b0, arb_err}, 32'd1);

        $display("[TB] test 6: reset with read outstanding");
        auto_mode = 1'b1;
        step();
        applyStimulus(1, 30'h60, '0, 4'b0, 0, '0, '0, 4'b0);
        exp_acc.push_back('{1'b0, 30'h60, 32'h0, 4'b0});
        step();
        reset = 1'b1;
        applyStimulus(1, 30'h61, '0, 4'b0, 1, 30'h62, '0, 4'b1);
        @(negedge clk);
        checkResetOutputs();
        step();
        reset = 1'b0;
        auto_mode = 1'b0;
        applyStimulus(0, '0, '0, 4'b0, 0, '0, '0, 4'b0);
        @(negedge clk);
        checkOutput("t6_err_cleared", {31'b0, arb_err}, 32'd0);
        step();
        man_valid = 1'b1; man_data = 32'h77;
        idle();
        @(negedge clk);
        checkOutput("t6_fifo_was_empty", {31'b0, arb_err}, 32'd1);
        idle();

        checkOutput("acc_queue_drained", exp_acc.size(), 32'd0);
        checkOutput("resp_queue_drained", exp_resp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-addressed CPU-side memory port between the instruction fetch requester (ic_*) and the data requester (dc_*).
- Memory port: valid/ready request, 4-bit byte write mask; reads return in order, writes return nothing.
- Grants one request per cycle. Data side has priority, with an anti-starvation limit for instruction side.
- Routes each read response back to its issuer using an in-order owner FIFO.
- Sits between the CPU front end/LSU and the memory model or cache.

Parameters:
- CPU_WIDTH, `CPU_INST_BITS (32), request/response data width.
- WORD_ADDR_BITS, `CPU_ADDR_BITS - `ceilLog2(`CPU_INST_BITS/8), word address width.
- MAX_STREAK, 4, maximum consecutive data grants while instruction side waits.
- OUTSTANDING, 2, owner FIFO depth (maximum reads in flight); power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ic_req_valid / dc_req_valid  in  1  request valid.
- ic_req_ready / dc_req_ready  out  1  request accepted this cycle.
- ic_req_addr / dc_req_addr  in  WORD_ADDR_BITS  word address.
- ic_req_data / dc_req_data  in  CPU_WIDTH  write data.
- ic_req_write / dc_req_write  in  4  byte write mask; 0 means read.
- ic_resp_valid / dc_resp_valid  out  1  read data valid.
- ic_resp_data / dc_resp_data  out  CPU_WIDTH  read data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr  out  WORD_ADDR_BITS  muxed address.
- mem_req_data  out  CPU_WIDTH  muxed data.
- mem_req_write  out  4  muxed write mask.
- mem_resp_valid  in  1  read response.
- mem_resp_data  in  CPU_WIDTH  read data.
- arb_err  out  1  sticky: a response arrived with no read outstanding.

Behaviour:
- Reset (synchronous): FIFO empty, count=0, streak=0, arb_err=0.
- While reset is high: mem_req_valid, both req_ready and both resp_valid are forced to 0.
- Eligibility, combinational:
  - A write (mask != 0) is always eligible.
  - A read is eligible only if FIFO count < OUTSTANDING. A pop in the same cycle does not free a slot.
- Grant selection, combinational, each cycle:
  - If both are valid and eligible: dc wins unless streak == MAX_STREAK, in which case ic wins.
  - If only one is valid and eligible, it wins. If neither, no grant.
- Request path:
  - mem_req_valid = grant exists. mem_req_addr/data/write come from the winner; when there is no grant they are the dc fields.
  - Winner's req_ready = mem_req_ready. Loser's req_ready = 0.
  - Zero added request latency.
- Handshake: a requester holds valid and its fields stable until ready. The arbiter may move the grant to the other requester while mem_req_ready is low (no lock).
- Accept = mem_req_valid & mem_req_ready.
- Streak update on each cycle:
  - Accept granted to dc while ic_req_valid: streak++ (saturates at MAX_STREAK).
  - Accept granted to ic, or ic_req_valid low: streak=0.
  - Otherwise hold.
- Owner FIFO:
  - Push the winner ID (0=ic, 1=dc) on a read accept.
  - Pop on mem_resp_valid.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo OUTSTANDING.
- Response routing, combinational, from the FIFO head:
  - Head 0: ic_resp_valid = mem_resp_valid. Head 1: dc_resp_valid = mem_resp_valid.
  - Both resp_data outputs = mem_resp_data.
- Response with FIFO empty: dropped (no resp_valid), no pop, arb_err set until reset.
- Writes never touch the FIFO. They may be accepted while reads are pending; memory preserves order.
- With a 1-cycle memory (reads respond the cycle after accept, ready always 1): back-to-back reads sustain 1 per cycle. Count never exceeds 1 at grant time.
- Reset mid-operation: FIFO cleared. Responses arriving afterwards are dropped and set arb_err. The memory is reset in the same cycle, so this does not occur in normal use.

Test Plan:
1. ic reads addr 0x10 alone, memory returns 0xDEADBEEF next cycle.
   -> ic_req_ready=1 in cycle 0; ic_resp_valid=1 with 0xDEADBEEF in cycle 1; dc_resp_valid stays 0.
2. Both request reads every cycle (ic addr 0x100, dc addr 0x200), MAX_STREAK=4.
   -> mem grants go dc,dc,dc,dc,ic repeating; each response is routed to its issuer.
3. dc write mask 4'b0011 data 0x1234 to 0x8 while ic read 0x8 is pending.
   -> write accepted the same cycle; FIFO count unchanged; ic response still routed to ic.
4. mem_req_ready=0 with OUTSTANDING=2 and two reads accepted, no responses yet.
   -> a third read gets ready=0; a write from the other side is still granted; after one response, the read is accepted.
5. mem_resp_valid pulsed with FIFO empty.
   -> no resp_valid on either side; arb_err=1 and stays 1 until reset.
6. reset asserted for 1 cycle with one read outstanding.
   -> next cycle count=0, streak=0, arb_err=0, all valid/ready outputs 0 during reset.
